// File: rtl/exmem_skid_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a head-entry forwarding lookup.
module exmem_skid_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_E,
    output logic              ready_E,
    input  logic              pcload_E,
    input  logic              regw_E,
    input  logic              memw_E,
    input  logic              regmem_E,
    input  logic [REG_W-1:0]  regScr_E,
    input  logic [DATA_W-1:0] ALUrslt_E,
    input  logic [DATA_W-1:0] address_E,
    output logic              valid_M,
    input  logic              ready_M,
    output logic              pcload_M,
    output logic              regw_M,
    output logic              memw_M,
    output logic              regmem_M,
    output logic [REG_W-1:0]  regScr_M,
    output logic [DATA_W-1:0] ALUrslt_M,
    output logic [DATA_W-1:0] address_M,
    input  logic [REG_W-1:0]  fwd_src,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PW = 4 + REG_W + 2 * DATA_W;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] head_q;
    logic          head_v;
    logic          push;
    logic          pop;

    assign in_pl = {pcload_E, regw_E, memw_E, regmem_E,
                    regScr_E, ALUrslt_E, address_E};
    assign push  = valid_E & ready_E;
    assign pop   = head_v & ready_M;

    if (SKID != 0) begin : g_skid
        localparam logic [1:0] S_EMPTY = 2'd0;
        localparam logic [1:0] S_ONE   = 2'd1;
        localparam logic [1:0] S_TWO   = 2'd2;

        logic [1:0]    state_q, state_d;
        logic [PW-1:0] head_d;
        logic [PW-1:0] skid_q, skid_d;
        logic          rdy_q;

        always_comb begin
            state_d = state_q;
            head_d  = head_q;
            skid_d  = skid_q;
            if (flush) begin
                state_d = S_EMPTY;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        if (push) begin
                            head_d  = in_pl;
                            state_d = S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (push && pop) begin
                            head_d = in_pl;
                        end else if (push) begin
                            skid_d  = in_pl;
                            state_d = S_TWO;
                        end else if (pop) begin
                            state_d = S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (pop) begin
                            head_d  = skid_q;
                            state_d = S_ONE;
                        end
                    end
                    default: state_d = S_EMPTY;
                endcase
            end
        end

        // ready is registered from the next state so ready_M never reaches ready_E
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= S_EMPTY;
                head_q  <= '0;
                skid_q  <= '0;
                rdy_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                head_q  <= head_d;
                skid_q  <= skid_d;
                rdy_q   <= (state_d != S_TWO);
            end
        end

        assign head_v  = (state_q != S_EMPTY);
        assign ready_E = rdy_q;
    end else begin : g_single
        logic head_v_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                head_v_q <= 1'b0;
                head_q   <= '0;
            end else if (flush) begin
                head_v_q <= 1'b0;
            end else if (push) begin
                head_v_q <= 1'b1;
                head_q   <= in_pl;
            end else if (pop) begin
                head_v_q <= 1'b0;
            end
        end

        assign head_v  = head_v_q;
        assign ready_E = !head_v_q | ready_M;
    end

    logic h_pc, h_rw, h_mw, h_rm;

    assign {h_pc, h_rw, h_mw, h_rm, regScr_M, ALUrslt_M, address_M} = head_q;

    // control bits are gated so a bubble can never write state downstream
    assign valid_M  = head_v;
    assign pcload_M = h_pc & head_v;
    assign regw_M   = h_rw & head_v;
    assign memw_M   = h_mw & head_v;
    assign regmem_M = h_rm & head_v;

    assign fwd_hit  = regw_M & (regScr_M == fwd_src);
    assign fwd_data = ALUrslt_M;

endmodule

// File: tb/tb_exmem_skid_pipe.sv
// Bench for exmem_skid_pipe: table vectors and scoreboard on the SKID=1 build,
// plus hand sequences for flush, async reset and the SKID=0 build.
module tb_exmem_skid_pipe;

    typedef struct packed {
        logic        pc;
        logic        rw;
        logic        mw;
        logic        rg;
        logic [3:0]  rs;
        logic [31:0] alu;
        logic [31:0] adr;
    } pl_t;

    typedef struct {
        logic        v;
        logic        rm;
        logic        rw;
        logic        mw;
        logic [3:0]  rs;
        logic [3:0]  fs;
        logic [31:0] alu;
        logic [31:0] adr;
        logic        ev;
        logic        er;
        logic        eh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, valid_E, ready_E, ready_M;
    logic        pcload_E, regw_E, memw_E, regmem_E;
    logic [3:0]  regScr_E, fwd_src;
    logic [31:0] ALUrslt_E, address_E;
    logic        valid_M, pcload_M, regw_M, memw_M, regmem_M, fwd_hit;
    logic [3:0]  regScr_M;
    logic [31:0] ALUrslt_M, address_M, fwd_data;

    logic        flush0, valid_E0, ready_E0, ready_M0;
    logic [3:0]  fwd_src0, regScr_M0;
    logic [31:0] ALUrslt_E0, ALUrslt_M0, address_M0, fwd_data0;
    logic        valid_M0, pcload_M0, regw_M0, memw_M0, regmem_M0, fwd_hit0;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    pl_t q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    exmem_skid_pipe #(.DATA_W(32), .REG_W(4), .SKID(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_E(valid_E), .ready_E(ready_E),
        .pcload_E(pcload_E), .regw_E(regw_E),
        .memw_E(memw_E), .regmem_E(regmem_E),
        .regScr_E(regScr_E), .ALUrslt_E(ALUrslt_E),
        .address_E(address_E),
        .valid_M(valid_M), .ready_M(ready_M),
        .pcload_M(pcload_M), .regw_M(regw_M),
        .memw_M(memw_M), .regmem_M(regmem_M),
        .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M),
        .address_M(address_M),
        .fwd_src(fwd_src), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    exmem_skid_pipe #(.DATA_W(32), .REG_W(4), .SKID(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .valid_E(valid_E0), .ready_E(ready_E0),
        .pcload_E(1'b0), .regw_E(1'b1),
        .memw_E(1'b0), .regmem_E(1'b0),
        .regScr_E(4'd2), .ALUrslt_E(ALUrslt_E0),
        .address_E(32'h40),
        .valid_M(valid_M0), .ready_M(ready_M0),
        .pcload_M(pcload_M0), .regw_M(regw_M0),
        .memw_M(memw_M0), .regmem_M(regmem_M0),
        .regScr_M(regScr_M0), .ALUrslt_M(ALUrslt_M0),
        .address_M(address_M0),
        .fwd_src(fwd_src0), .fwd_hit(fwd_hit0), .fwd_data(fwd_data0)
    );

    task automatic chk(input string nm, input logic [95:0] got,
                       input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rm, input logic fl,
                         input pl_t p, input logic [3:0] fs);
        valid_E  = v;
        ready_M  = rm;
        flush    = fl;
        {pcload_E, regw_E, memw_E, regmem_E,
         regScr_E, ALUrslt_E, address_E} = p;
        fwd_src  = fs;
    endtask

    // model of the SKID=1 build, evaluated once per cycle before the edge
    task automatic sb();
        pl_t got;
        pl_t cur;
        got = {pcload_M, regw_M, memw_M, regmem_M,
               regScr_M, ALUrslt_M, address_M};
        cur = {pcload_E, regw_E, memw_E, regmem_E,
               regScr_E, ALUrslt_E, address_E};
        chk("sb_valid", valid_M, q.size() != 0);
        chk("sb_ready", ready_E, q.size() < 2);
        if (q.size() != 0) begin
            chk("sb_head", got, q[0]);
            chk("sb_fwd_data", fwd_data, q[0].alu);
        end else begin
            chk("sb_gate", {pcload_M, regw_M, memw_M, regmem_M}, 4'b0);
        end
        if (flush) begin
            q.delete();
        end else begin
            logic do_push;
            do_push = valid_E && (q.size() < 2);
            if (ready_M && q.size() != 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (do_push) q.push_back(cur);
        end
    endtask

    task automatic adv();
        sb();
        @(negedge clk);
    endtask

    function automatic pl_t mk(logic rw, logic mw, logic [3:0] rs,
                               logic [31:0] alu, logic [31:0] adr);
        pl_t p;
        p = '{pc: 1'b0, rw: rw, mw: mw, rg: 1'b0,
              rs: rs, alu: alu, adr: adr};
        return p;
    endfunction

    initial begin
        vecs[0]  = '{1, 0, 1, 0, 3, 3, 32'h0000FFFF, 32'h00010004, 0, 1, 0};
        vecs[1]  = '{1, 0, 1, 1, 4, 3, 32'h00001234, 32'h00020008, 1, 1, 1};
        vecs[2]  = '{1, 0, 1, 0, 5, 4, 32'h00005555, 32'h0003000C, 1, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 3, 32'h0,        32'h0,        1, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 4, 32'h0,        32'h0,        1, 1, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 5, 32'h0,        32'h0,        1, 1, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 4, 32'h0,        32'h0,        1, 1, 1};
        vecs[7]  = '{0, 1, 0, 0, 0, 4, 32'h0,        32'h0,        0, 1, 0};
        vecs[8]  = '{1, 0, 0, 0, 7, 7, 32'h00000077, 32'h00000070, 0, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 7, 32'h0,        32'h0,        1, 1, 0};
        vecs[10] = '{0, 1, 0, 0, 0, 7, 32'h0,        32'h0,        1, 1, 0};
        vecs[11] = '{0, 1, 0, 0, 0, 7, 32'h0,        32'h0,        0, 1, 0};

        rst        = 1'b0;
        flush0     = 1'b0;
        valid_E0   = 1'b0;
        ready_M0   = 1'b0;
        ALUrslt_E0 = '0;
        fwd_src0   = '0;
        drive(1, 1, 0, mk(1, 1, 4'd9, 32'hDEAD, 32'hBEEF), 4'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_valid", valid_M, 1'b0);
        chk("rst_ready", ready_E, 1'b1);
        chk("rst_ctrl", {pcload_M, regw_M, memw_M, regmem_M}, 4'b0);
        chk("rst_pay", {regScr_M, ALUrslt_M, address_M}, 68'b0);
        chk("rst_hit", fwd_hit, 1'b0);
        chk("rst_valid0", valid_M0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].rm, 0,
                  mk(vecs[i].rw, vecs[i].mw, vecs[i].rs,
                     vecs[i].alu, vecs[i].adr), vecs[i].fs);
            #2;
            chk($sformatf("vec%0d_valid", i), valid_M, vecs[i].ev);
            chk($sformatf("vec%0d_ready", i), ready_E, vecs[i].er);
            chk($sformatf("vec%0d_hit", i), fwd_hit, vecs[i].eh);
            if (i == 4) chk("vec4_fwd", fwd_data, 32'h1234);
            adv();
        end

        pops = 0;
        for (int i = 0; i < 10; i++) begin
            pl_t p;
            p = mk(i[0], i[1], 4'(i), 32'(i), 32'(i * 4));
            p.pc = i[2];
            p.rg = ~i[0];
            drive(i < 8, 1, 0, p, 4'd15);
            #2;
            if (i >= 1 && i <= 8) begin
                chk($sformatf("stream%0d_v", i), valid_M, 1'b1);
                chk($sformatf("stream%0d_d", i), ALUrslt_M, 32'(i - 1));
            end
            adv();
        end
        chk("stream_pops", pops, 8);

        drive(1, 0, 0, mk(1, 1, 4'd1, 32'hA0, 32'h100), 4'd0);
        #2;
        adv();
        drive(1, 0, 0, mk(1, 1, 4'd2, 32'hA1, 32'h104), 4'd0);
        #2;
        adv();
        drive(1, 0, 1, mk(1, 1, 4'd3, 32'hEE, 32'h108), 4'd0);
        #2;
        chk("flush_two", ready_E, 1'b0);
        adv();
        drive(0, 1, 0, mk(0, 0, 4'd0, 32'h0, 32'h0), 4'd0);
        #2;
        chk("flush_valid", valid_M, 1'b0);
        chk("flush_memw", memw_M, 1'b0);
        chk("flush_ready", ready_E, 1'b1);
        adv();
        #2;
        chk("flush_gone", valid_M, 1'b0);
        adv();

        drive(1, 0, 0, mk(1, 1, 4'd6, 32'hC0, 32'h200), 4'd0);
        #2;
        adv();
        drive(1, 0, 0, mk(1, 0, 4'd7, 32'hC1, 32'h204), 4'd0);
        #2;
        adv();
        drive(0, 0, 0, mk(0, 0, 4'd0, 32'h0, 32'h0), 4'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", valid_M, 1'b0);
        chk("arst_memw", memw_M, 1'b0);
        chk("arst_alu", ALUrslt_M, 32'h0);
        chk("arst_ready", ready_E, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        #2;
        adv();

        valid_E0   = 1'b1;
        ready_M0   = 1'b0;
        ALUrslt_E0 = 32'h55;
        #2;
        chk("s0_ready_empty", ready_E0, 1'b1);
        @(negedge clk);
        valid_E0 = 1'b0;
        fwd_src0 = 4'd2;
        #2;
        chk("s0_valid", valid_M0, 1'b1);
        chk("s0_data", ALUrslt_M0, 32'h55);
        chk("s0_hit", fwd_hit0, 1'b1);
        chk("s0_ready_full", ready_E0, 1'b0);
        ready_M0 = 1'b1;
        #1;
        chk("s0_ready_comb", ready_E0, 1'b1);
        @(negedge clk);
        ready_M0 = 1'b0;
        #2;
        chk("s0_drained", valid_M0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
